cp0_int_ctrl: RTL and testbench

Parametrised coprocessor-0 interrupt/exception controller that sits beside the M stage of the 5-stage pipeline.
- Synchronises `NUM_INT` external hardware interrupt lines, each with a per-channel level or edge capture mode.
- Holds the SR, Cause, EPC and PRId registers, decides interrupt/exception entry and ERET, and supplies the redirect PC to Fetch.
- Generalises the fixed 6-line level-only scheme to configurable width, synchroniser depth and capture mode.

---
 rtl/cp0_int_ctrl_if.sv | 29 ++
 rtl/cp0_int_ctrl.sv | 138 +++++++++++++
 tb/tb_cp0_int_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_int_ctrl_if.sv
// Pipeline <-> CP0 interrupt/exception controller signal bundle.
// master = M-stage/pipeline side, slave = the controller.
interface cp0_int_ctrl_if #(
  parameter int unsigned NUM_INT = 6
);
  logic [NUM_INT-1:0] hw_int;
  logic               we;
  logic [4:0]         addr;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic [31:0]        pc_m;
  logic               bd_m;
  logic               exc_req;
  logic [4:0]         exc_code;
  logic               eret;
  logic               take;
  logic [31:0]        redirect_pc;
  logic [31:0]        epc;

  modport master (
    output hw_int, we, addr, wdata, pc_m, bd_m, exc_req, exc_code, eret,
    input  rdata, take, redirect_pc, epc
  );

  modport slave (
    input  hw_int, we, addr, wdata, pc_m, bd_m, exc_req, exc_code, eret,
    output rdata, take, redirect_pc, epc
  );
endinterface

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt/exception controller: line synchronisers, SR/Cause/EPC/PRId,
// exception entry / ERET decision and Fetch redirect target.
module cp0_int_ctrl #(
  parameter int unsigned NUM_INT     = 6,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [5:0]  EDGE_MASK   = 6'b000000,
  parameter logic [31:0] PRID        = 32'h4C5A_0001,
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_4180
) (
  input  logic          clk,
  input  logic          reset,
  cp0_int_ctrl_if.slave bus
);

  localparam int unsigned IPW   = 6;
  localparam logic [4:0]  A_SR    = 5'd12;
  localparam logic [4:0]  A_CAUSE = 5'd13;
  localparam logic [4:0]  A_EPC   = 5'd14;
  localparam logic [4:0]  A_PRID  = 5'd15;

  typedef enum logic {NORMAL = 1'b0, HANDLER = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [NUM_INT-1:0] s_c, s_prev_q, ip_q, ip_d;
  logic               ie_q, ie_d;
  logic [IPW-1:0]     im_q, im_d;
  logic               bd_q, bd_d;
  logic [4:0]         exc_code_q, exc_code_d;
  logic [31:0]        epc_q, epc_d;

  logic               exl_c, int_pend_c, exc_ok_c, take_c;
  logic [IPW-1:0]     ip_c;
  logic               wr_sr_c, wr_cause_c, wr_epc_c;
  logic [31:0]        epc_take_c;

  // Per-line synchroniser chain; zero stages uses the raw line directly.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s_c = bus.hw_int;
    end else begin : g_sync
      logic [NUM_INT-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
          sync_q[0] <= bus.hw_int;
          for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign s_c = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign exl_c      = (state_q == HANDLER);
  assign ip_c       = IPW'(ip_q);
  assign int_pend_c = ie_q & ~exl_c & (|(ip_c & im_q));
  assign exc_ok_c   = bus.exc_req & ~exl_c;
  assign take_c     = int_pend_c | exc_ok_c;

  // mtc0 is dropped whenever the same cycle redirects to the handler.
  assign wr_sr_c    = bus.we & (bus.addr == A_SR)    & ~take_c;
  assign wr_cause_c = bus.we & (bus.addr == A_CAUSE) & ~take_c;
  assign wr_epc_c   = bus.we & (bus.addr == A_EPC)   & ~take_c;
  assign epc_take_c = bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m;

  always_comb begin
    state_d    = state_q;
    ip_d       = ip_q;
    ie_d       = ie_q;
    im_d       = im_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;

    // Edge lines are sticky W1C; a new edge beats a same-cycle clear.
    for (int unsigned i = 0; i < NUM_INT; i++) begin
      if (EDGE_MASK[i]) begin
        ip_d[i] = (s_c[i] & ~s_prev_q[i]) | (ip_q[i] & ~(wr_cause_c & bus.wdata[10+i]));
      end else begin
        ip_d[i] = s_c[i];
      end
    end

    if (take_c) begin
      state_d    = HANDLER;
      bd_d       = bus.bd_m;
      epc_d      = {epc_take_c[31:2], 2'b00};
      exc_code_d = int_pend_c ? 5'd0 : bus.exc_code;
    end else begin
      if (wr_sr_c) begin
        ie_d    = bus.wdata[0];
        im_d    = bus.wdata[15:10];
        state_d = bus.wdata[1] ? HANDLER : NORMAL;
      end
      if (bus.eret) state_d = NORMAL;
      if (wr_epc_c) epc_d = {bus.wdata[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= NORMAL;
      s_prev_q   <= '0;
      ip_q       <= '0;
      ie_q       <= 1'b0;
      im_q       <= '0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      state_q    <= state_d;
      s_prev_q   <= s_c;
      ip_q       <= ip_d;
      ie_q       <= ie_d;
      im_q       <= im_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // mfc0 read mux shows pre-edge register state.
  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      A_SR:    bus.rdata = {16'd0, im_q, 8'd0, exl_c, ie_q};
      A_CAUSE: bus.rdata = {bd_q, 15'd0, ip_c, 3'd0, exc_code_q, 2'd0};
      A_EPC:   bus.rdata = epc_q;
      A_PRID:  bus.rdata = PRID;
      default: bus.rdata = '0;
    endcase
  end

  assign bus.take        = take_c;
  assign bus.redirect_pc = take_c ? EXC_VECTOR : epc_q;
  assign bus.epc         = epc_q;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Directed bench for cp0_int_ctrl (2 sync stages, line 1 edge-captured)
// with an expected-value scoreboard queue.
module tb_cp0_int_ctrl;

  localparam int unsigned NUM_INT = 6;

  logic clk = 1'b0;
  logic reset;

  cp0_int_ctrl_if #(.NUM_INT(NUM_INT)) bus ();

  cp0_int_ctrl #(
    .NUM_INT    (NUM_INT),
    .SYNC_STAGES(2),
    .EDGE_MASK  (6'b000010),
    .PRID       (32'h4C5A_0001),
    .EXC_VECTOR (32'h0000_4180)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL sb_underflow observed=%08h expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%08h expected=%08h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rd(input string tag, input logic [4:0] a, input logic [31:0] v);
    push_exp(tag, v);
    bus.addr = a;
    #1;
    observe(bus.rdata);
  endtask

  task automatic chk_take(input string tag, input logic v);
    push_exp(tag, {31'd0, v});
    #1;
    observe({31'd0, bus.take});
  endtask

  task automatic chk_rpc(input string tag, input logic [31:0] v);
    push_exp(tag, v);
    #1;
    observe(bus.redirect_pc);
  endtask

  task automatic chk_epc(input string tag, input logic [31:0] v);
    push_exp(tag, v);
    #1;
    observe(bus.epc);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    tick();
    bus.we    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    bus.hw_int   = '1;
    bus.we       = 1'b0;
    bus.addr     = 5'd0;
    bus.wdata    = 32'd0;
    bus.pc_m     = 32'd0;
    bus.bd_m     = 1'b0;
    bus.exc_req  = 1'b0;
    bus.exc_code = 5'd0;
    bus.eret     = 1'b0;

    // Reset with every line high.
    tick();
    tick();
    chk_take("rst_take", 1'b0);
    chk_rd("rst_sr", 5'd12, 32'd0);
    chk_rd("rst_cause", 5'd13, 32'd0);
    chk_rd("rst_epc", 5'd14, 32'd0);
    chk_epc("rst_epc_out", 32'd0);

    // IP fills SYNC_STAGES+1 edges after release.
    reset = 1'b1;
    chk_rd("fill0", 5'd13, 32'd0);
    tick();
    chk_rd("fill1", 5'd13, 32'd0);
    tick();
    chk_rd("fill2", 5'd13, 32'd0);
    tick();
    chk_rd("fill3", 5'd13, 32'h0000_FC00);
    chk_take("fill_no_take", 1'b0);

    // Level bits drop, edge bit 11 stays sticky until W1C.
    bus.hw_int = '0;
    tick(); tick(); tick();
    chk_rd("sticky", 5'd13, 32'h0000_0800);
    mtc0(5'd13, 32'h0000_0800);
    chk_rd("w1c", 5'd13, 32'd0);

    // Level interrupt on line 0.
    mtc0(5'd12, 32'h0000_0401);
    chk_rd("sr_wr", 5'd12, 32'h0000_0401);
    bus.pc_m   = 32'h0000_3010;
    bus.bd_m   = 1'b0;
    bus.hw_int = 6'b000001;
    tick();
    chk_take("lvl_c1", 1'b0);
    tick();
    chk_take("lvl_c2", 1'b0);
    tick();
    chk_take("lvl_c3", 1'b1);
    chk_rpc("lvl_vec", 32'h0000_4180);
    tick();
    chk_take("lvl_exl_mask", 1'b0);
    chk_epc("lvl_epc", 32'h0000_3010);
    chk_rd("lvl_sr", 5'd12, 32'h0000_0403);
    chk_rd("lvl_cause", 5'd13, 32'h0000_0400);
    bus.hw_int = '0;
    tick(); tick(); tick();
    bus.eret = 1'b1;
    chk_rpc("lvl_eret_rpc", 32'h0000_3010);
    chk_take("lvl_eret_take", 1'b0);
    tick();
    bus.eret = 1'b0;
    chk_rd("lvl_post_sr", 5'd12, 32'h0000_0401);
    chk_take("lvl_post_take", 1'b0);

    // Edge capture on line 1 with IE=0.
    mtc0(5'd12, 32'h0000_0000);
    bus.hw_int = 6'b000010;
    tick();
    bus.hw_int = '0;
    tick(); tick(); tick();
    chk_rd("edge_ip", 5'd13, 32'h0000_0800);
    chk_take("edge_ie0", 1'b0);
    mtc0(5'd12, 32'h0000_0801);
    chk_take("edge_take", 1'b1);

    // Delay slot + interrupt priority + discarded mtc0 EPC, no bypass.
    bus.exc_req  = 1'b1;
    bus.exc_code = 5'd12;
    bus.bd_m     = 1'b1;
    bus.pc_m     = 32'h0000_3024;
    bus.we       = 1'b1;
    bus.wdata    = 32'h1234_5677;
    chk_rd("no_bypass", 5'd14, 32'h0000_3010);
    chk_rpc("prio_vec", 32'h0000_4180);
    tick();
    bus.we = 1'b0;
    chk_epc("ds_epc", 32'h0000_3020);
    chk_rd("ds_cause", 5'd13, 32'h8000_0800);
    chk_rd("ds_sr", 5'd12, 32'h0000_0803);
    chk_take("exl_blocks_exc", 1'b0);

    // ERET, then the still-pending edge bit fires again.
    bus.exc_req = 1'b0;
    bus.bd_m    = 1'b0;
    bus.eret    = 1'b1;
    chk_rpc("eret_rpc", 32'h0000_3020);
    chk_take("eret_take", 1'b0);
    tick();
    bus.eret = 1'b0;
    bus.pc_m = 32'h0000_3040;
    chk_take("refire", 1'b1);
    tick();
    chk_epc("refire_epc", 32'h0000_3040);
    mtc0(5'd13, 32'h0000_0800);
    chk_rd("clr_cause", 5'd13, 32'd0);
    mtc0(5'd14, 32'h1234_5677);
    chk_rd("epc_wr", 5'd14, 32'h1234_5674);
    chk_epc("epc_wr_out", 32'h1234_5674);

    // mtc0 SR with EXL=0 leaves handler; synchronous exception taken.
    mtc0(5'd12, 32'h0000_0000);
    chk_rd("sr_exit", 5'd12, 32'd0);
    bus.exc_req  = 1'b1;
    bus.exc_code = 5'd12;
    bus.pc_m     = 32'h0000_5000;
    chk_take("exc_take", 1'b1);
    tick();
    bus.exc_req = 1'b0;
    chk_rd("exc_cause", 5'd13, 32'h0000_0030);
    chk_epc("exc_epc", 32'h0000_5000);
    chk_rd("prid", 5'd15, 32'h4C5A_0001);
    chk_rd("unmapped", 5'd5, 32'd0);

    // Reset overrides a simultaneous mtc0.
    reset     = 1'b0;
    bus.we    = 1'b1;
    bus.addr  = 5'd14;
    bus.wdata = 32'hDEAD_BEEC;
    tick();
    bus.we = 1'b0;
    chk_rd("rst2_sr", 5'd12, 32'd0);
    chk_epc("rst2_epc", 32'd0);
    reset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
